hc595_chain_seg7_driver: RTL and testbench
==========================================

# hc595_chain_seg7_driver

Parametrised serial driver for a daisy-chain of DIGITS 74HC595 shift registers, each driving one 7-segment digit plus decimal point. On a start request it decodes hex nibbles, applies per-digit decimal-point and blanking masks and the configured segment polarity, then shifts the frame out MSB-first on sclk/sdata and pulses rclk to latch all digits at once. It sits between the numeric datapath, which provides the values, and the board's '595 chain. Compared with the earlier three-digit BCD driver, it adds a configurable digit count, clock divider and polarity, hex glyphs, per-digit DP and blanking masks, and a busy/done handshake.

## Interface
- DIGITS, 4: number of chained '595/digit pairs; legal range 1..16
- CLK_DIV, 250: clk cycles per sclk half-period; minimum 1
- ACTIVE_LOW, 1: 1 = segment on drives 0 (common-anode); 0 = segment on drives 1
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  frame request; sampled every clk
- digits  in  4*DIGITS  hex nibble per digit; digit i is at [4i+3:4i]
- dp  in  DIGITS  decimal point on for digit i
- blank  in  DIGITS  digit i shows all segments off, including DP
- sclk  out  1  '595 SRCLK
- sdata  out  1  '595 SER
- rclk  out  1  '595 RCLK (latch)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end

## Operation
- Glyph byte, active-high form: bit7 = DP, bits6..0 = g..a.
- Hex codes: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Per digit: byte = blank ? 00 : (code | dp<<7); the byte is inverted when ACTIVE_LOW = 1.
- FSM states are IDLE, SHIFT and LATCH.
- IDLE -> SHIFT when start = 1. All digit bytes are captured into an 8*DIGITS shift register in the same cycle. Input changes after capture have no effect on the frame.
- Shift order: digit DIGITS-1 first, bit7 first within each byte, down to digit 0 bit0.
- SHIFT: each bit occupies one sclk period.
  - sdata holds the bit for CLK_DIV cycles with sclk = 0.
  - sclk is then 1 for CLK_DIV cycles.
  - The next bit is presented as sclk falls.
- SHIFT -> LATCH after the high phase of bit 8*DIGITS-1. sdata holds its last value and sclk = 0.
- LATCH: rclk = 1 for CLK_DIV cycles, then -> IDLE.
- start while busy = 1 is ignored; requests are not queued.
- Counters:
  - Divider counter is clog2(CLK_DIV) bits wide, or 1 bit when CLK_DIV = 1.
  - Bit counter is clog2(8*DIGITS) bits wide.
  - There is no wrap-around beyond the terminal counts.

## Timing
- Reset values: sclk = 0, sdata = 0, rclk = 0, busy = 0, done = 0; FSM in IDLE.
- start is sampled high at cycle 0. From cycle 1:
  - busy = 1;
  - sdata = first bit;
  - sclk = 0.
- busy stays high for exactly (16*DIGITS+1)*CLK_DIV cycles.
- The first sclk rise is at cycle 1+CLK_DIV.
- rclk rises CLK_DIV cycles after the last sclk rise and lasts CLK_DIV cycles. It never overlaps sclk = 1.
- done = 1 for one cycle, in the first cycle with busy = 0.
- start sampled during the done cycle is accepted, so frames can run back-to-back.
- Reset asserted mid-frame:
  - all outputs return to their reset values immediately;
  - no rclk and no done are produced;
  - the next frame needs a new start.

## Structure
- Shared package `seg7_pkg`:
  - 16-entry active-high glyph constants;
  - constants SEG_DP_BIT = 7, SEG_OFF = 8'h00.
- Sub-module `seg7_hex_encode`: nibble, dp, blank and ACTIVE_LOW in, byte out.
  - One instance per digit, in a generate loop.
  - The top level holds the FSM, divider, bit counter and shift register.

## Test plan
- Reset check: assert rst_n = 0 -> all five outputs are 0. Release, then hold start = 0 -> outputs stay 0 and busy stays 0.
- Basic frame, DIGITS = 3, CLK_DIV = 2, ACTIVE_LOW = 1, digits = 12'h123, dp = 3'b010, blank = 0, single start pulse:
  - bits sampled at the sclk rises form the stream F9 24 B0;
  - exactly 24 sclk rises occur, then one rclk pulse of 2 cycles;
  - busy lasts 98 cycles, followed by a 1-cycle done.
- Hex and blanking, same configuration, digits = 12'hAF6, blank = 3'b100, dp = 0 -> stream FF 8E 82.
- Busy and input isolation:
  - extra start pulses and a change of digits during the frame produce no second frame and leave the frame data unchanged;
  - start in the done cycle begins a new frame on the next cycle.
- Reset mid-frame: assert rst_n after the 10th sclk rise -> all outputs are 0, no rclk, no done. A later start gives a complete, correct frame.
- Polarity and divider edge, DIGITS = 1, CLK_DIV = 1, ACTIVE_LOW = 0, digits = 4'h8, dp = 1:
  - stream FF;
  - busy lasts 17 cycles;
  - sclk toggles every cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-high glyphs (bit7 = DP, bits6..0 = g..a) and driver FSM states.
// Pure constants and a lookup helper; no timing or flow control of its own.
package seg7_pkg;

  localparam int         SEG_DP_BIT = 7;
  localparam logic [7:0] SEG_OFF    = 8'h00;

  // Entry n is the glyph for hex digit n; index 15 is written first.
  localparam logic [15:0][7:0] SEG_GLYPH = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } drv_state_t;

  function automatic logic [7:0] seg7_glyph(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/hc595_chain_seg7_driver_if.sv
// Request/status and '595 serial bundle between the numeric datapath and the driver.
// Master is the requester; slave is the driver that owns the serial pins and busy/done.
interface hc595_chain_seg7_driver_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   digits;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank;
  logic                  sclk;
  logic                  sdata;
  logic                  rclk;
  logic                  busy;
  logic                  done;

  modport master (
    output start, digits, dp, blank,
    input  sclk, sdata, rclk, busy, done
  );

  modport slave (
    input  start, digits, dp, blank,
    output sclk, sdata, rclk, busy, done
  );
endinterface

// File: rtl/seg7_hex_encode.sv
// Combinational hex nibble -> 7-segment byte with DP, blanking and output polarity applied.
// Zero latency; no flow control.
module seg7_hex_encode
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] seg_hi;

  // Blanking wins over DP so a blanked digit is fully dark.
  always_comb begin
    seg_hi = SEG_OFF;
    if (!blank) begin
      seg_hi             = seg7_glyph(nibble);
      seg_hi[SEG_DP_BIT] = dp;
    end
  end

  assign seg = ACTIVE_LOW ? ~seg_hi : seg_hi;

endmodule

// File: rtl/hc595_chain_seg7_driver.sv
// Captures one frame on start, shifts it MSB-first to a '595 chain, then pulses rclk; busy (16*DIGITS+1)*CLK_DIV cycles.
// start is ignored while busy (no queueing); a start in the done cycle begins the next frame immediately.
module hc595_chain_seg7_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 250,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  hc595_chain_seg7_driver_if.slave    bus
);

  localparam int FRAME_W = 8 * DIGITS;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  logic [FRAME_W-1:0] frame;

  drv_state_t         state_q, state_d;
  logic [DIV_W-1:0]   div_q,   div_d;
  logic [BIT_W-1:0]   bit_q,   bit_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               sclk_q,  sclk_d;
  logic               done_q,  done_d;

  // Digit i lands in byte i, so the highest digit sits at the MSB and leaves first.
  for (genvar i = 0; i < DIGITS; i++) begin : g_enc
    seg7_hex_encode #(
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_enc (
      .nibble (bus.digits[4*i +: 4]),
      .dp     (bus.dp[i]),
      .blank  (bus.blank[i]),
      .seg    (frame[8*i +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          shift_d = frame;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // The last bit stays on sdata through the latch phase.
            if (bit_q == BIT_LAST) begin
              state_d = ST_LATCH;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.sclk  = sclk_q;
  assign bus.sdata = shift_q[FRAME_W-1];
  assign bus.rclk  = (state_q == ST_LATCH);
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_hc595_chain_seg7_driver.sv
// Directed bench for two driver configurations; bytes seen at sclk rises are scored against a queue
// filled from an independent glyph model when each start is issued.
module tb_hc595_chain_seg7_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hc595_chain_seg7_driver_if #(.DIGITS(3)) bus_a ();
  hc595_chain_seg7_driver_if #(.DIGITS(1)) bus_b ();

  hc595_chain_seg7_driver #(.DIGITS(3), .CLK_DIV(2), .ACTIVE_LOW(1'b1)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  hc595_chain_seg7_driver #(.DIGITS(1), .CLK_DIV(1), .ACTIVE_LOW(1'b0)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] tb_glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [3:0] n, input logic p,
                                            input logic b, input logic al);
    logic [7:0] g;
    g = b ? 8'h00 : (tb_glyph[n] | {p, 7'b0});
    return al ? ~g : g;
  endfunction

  // Per-DUT observers: cumulative counts, sampled on the falling edge.
  int rises_a = 0, hi_a = 0, ovl_a = 0, rpulse_a = 0, rlen_a = 0, last_rlen_a = 0;
  int run_a = 0, last_run_a = 0, done_cnt_a = 0, nb_a = 0;
  logic prev_sclk_a = 0, prev_rclk_a = 0, prev_busy_a = 0, done_fall_a = 0;
  logic [7:0] acc_a = 0;
  int rises_b = 0, hi_b = 0, ovl_b = 0, rpulse_b = 0, rlen_b = 0, last_rlen_b = 0;
  int run_b = 0, last_run_b = 0, done_cnt_b = 0, nb_b = 0;
  logic prev_sclk_b = 0, prev_rclk_b = 0, prev_busy_b = 0, done_fall_b = 0;
  logic [7:0] acc_b = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nb_a = 0; run_a = 0; rlen_a = 0;
      prev_sclk_a = 0; prev_rclk_a = 0; prev_busy_a = 0;
    end else begin
      if (bus_a.sclk && !prev_sclk_a) begin
        rises_a++;
        acc_a = {acc_a[6:0], bus_a.sdata};
        nb_a++;
        if (nb_a == 8) begin
          nb_a = 0;
          check("byte_a_expected", 32'(exp_a.size() > 0), 1);
          if (exp_a.size() > 0) check("byte_a", acc_a, exp_a.pop_front());
        end
      end
      if (bus_a.sclk) hi_a++;
      if (bus_a.sclk && bus_a.rclk) ovl_a++;
      if (bus_a.rclk) rlen_a++;
      else if (prev_rclk_a) begin last_rlen_a = rlen_a; rpulse_a++; rlen_a = 0; end
      if (bus_a.busy) run_a++;
      else if (prev_busy_a) begin last_run_a = run_a; run_a = 0; done_fall_a = bus_a.done; end
      if (bus_a.done) done_cnt_a++;
      prev_sclk_a = bus_a.sclk; prev_rclk_a = bus_a.rclk; prev_busy_a = bus_a.busy;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      nb_b = 0; run_b = 0; rlen_b = 0;
      prev_sclk_b = 0; prev_rclk_b = 0; prev_busy_b = 0;
    end else begin
      if (bus_b.sclk && !prev_sclk_b) begin
        rises_b++;
        acc_b = {acc_b[6:0], bus_b.sdata};
        nb_b++;
        if (nb_b == 8) begin
          nb_b = 0;
          check("byte_b_expected", 32'(exp_b.size() > 0), 1);
          if (exp_b.size() > 0) check("byte_b", acc_b, exp_b.pop_front());
        end
      end
      if (bus_b.sclk) hi_b++;
      if (bus_b.sclk && bus_b.rclk) ovl_b++;
      if (bus_b.rclk) rlen_b++;
      else if (prev_rclk_b) begin last_rlen_b = rlen_b; rpulse_b++; rlen_b = 0; end
      if (bus_b.busy) run_b++;
      else if (prev_busy_b) begin last_run_b = run_b; run_b = 0; done_fall_b = bus_b.done; end
      if (bus_b.done) done_cnt_b++;
      prev_sclk_b = bus_b.sclk; prev_rclk_b = bus_b.rclk; prev_busy_b = bus_b.busy;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after start was sampled.
  task automatic start_a(input logic [11:0] d, input logic [2:0] p, input logic [2:0] b);
    bus_a.digits = d; bus_a.dp = p; bus_a.blank = b;
    for (int i = 2; i >= 0; i--) exp_a.push_back(model_byte(d[4*i +: 4], p[i], b[i], 1'b1));
    bus_a.start = 1'b1;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      seen = bus_a.done;
    end
    check(tag, 32'(seen), 1);
  endtask

  int r0, p0, d0;
  logic seen_busy;
  logic reached;

  initial begin
    bus_a.start = 0; bus_a.digits = '0; bus_a.dp = '0; bus_a.blank = '0;
    bus_b.start = 0; bus_b.digits = '0; bus_b.dp = '0; bus_b.blank = '0;
    #12;
    check("reset_a_outputs", {bus_a.sclk, bus_a.sdata, bus_a.rclk, bus_a.busy, bus_a.done}, 0);
    check("reset_b_outputs", {bus_b.sclk, bus_b.sdata, bus_b.rclk, bus_b.busy, bus_b.done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen_busy |= bus_a.busy | bus_a.sclk | bus_a.sdata | bus_a.rclk | bus_a.done;
    end
    check("idle_no_start", 32'(seen_busy), 0);

    // DIGITS=1, CLK_DIV=1, active-high segments.
    bus_b.digits = 4'h8; bus_b.dp = 1'b1; bus_b.blank = 1'b0;
    exp_b.push_back(model_byte(4'h8, 1'b1, 1'b0, 1'b0));
    bus_b.start = 1'b1;
    @(posedge clk); #1;
    bus_b.start = 1'b0;
    check("b_first_cycle", {bus_b.busy, bus_b.sclk, bus_b.sdata}, 3'b101);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(posedge clk); #1;
      reached = bus_b.done;
    end
    check("b_done_seen", 32'(reached), 1);
    @(posedge clk); #1;
    check("b_done_width", 32'(bus_b.done), 0);
    check("b_busy_len", last_run_b, 17);
    check("b_sclk_rises", rises_b, 8);
    check("b_sclk_high_cycles", hi_b, 8);
    check("b_rclk_pulses", rpulse_b, 1);
    check("b_rclk_len", last_rlen_b, 1);
    check("b_done_at_busy_fall", 32'(done_fall_b), 1);
    check("b_sb_empty", exp_b.size(), 0);

    // Basic frame: expect F9 24 B0.
    r0 = rises_a; p0 = rpulse_a;
    start_a(12'h123, 3'b010, 3'b000);
    check("a_first_cycle", {bus_a.busy, bus_a.sclk, bus_a.sdata}, 3'b101);
    wait_done_a("a_done1");
    check("a_rises1", rises_a - r0, 24);
    // Back-to-back: start during the done cycle; expect FF 8E 82.
    start_a(12'hAF6, 3'b000, 3'b100);
    check("a_b2b_first_cycle", {bus_a.busy, bus_a.sclk, bus_a.sdata}, 3'b101);
    check("a_busy_len1", last_run_a, 98);
    check("a_rclk_len1", last_rlen_a, 2);
    check("a_rclk_pulses1", rpulse_a - p0, 1);
    check("a_done_at_busy_fall", 32'(done_fall_a), 1);

    // Extra starts and input changes mid-frame must not disturb it.
    r0 = rises_a; p0 = rpulse_a; d0 = done_cnt_a;
    repeat (7) @(posedge clk); #1;
    bus_a.start = 1'b1; bus_a.digits = 12'h000; bus_a.dp = 3'b111;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    repeat (20) @(posedge clk); #1;
    bus_a.start = 1'b1; bus_a.blank = 3'b011;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    wait_done_a("a_done2");
    @(posedge clk); #1;
    check("a_done_width", 32'(bus_a.done), 0);
    repeat (60) @(posedge clk); #1;
    check("a_no_second_frame_busy", 32'(bus_a.busy), 0);
    check("a_rises2", rises_a - r0, 24);
    check("a_rclk_pulses2", rpulse_a - p0, 1);
    check("a_done_count2", done_cnt_a - d0, 1);
    check("a_busy_len2", last_run_a, 98);
    check("a_sb_empty2", exp_a.size(), 0);

    // Reset after the 10th sclk rise.
    start_a(12'h0E8, 3'b001, 3'b000);
    r0 = rises_a - 0; p0 = rpulse_a; d0 = done_cnt_a;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(posedge clk); #1;
      reached = (rises_a - r0) >= 10;
    end
    check("a_reached_10_rises", 32'(reached), 1);
    rst_n = 1'b0;
    #1;
    check("a_midframe_reset_outputs",
          {bus_a.sclk, bus_a.sdata, bus_a.rclk, bus_a.busy, bus_a.done}, 0);
    exp_a.delete();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (250) @(posedge clk); #1;
    check("a_reset_no_rclk", rpulse_a - p0, 0);
    check("a_reset_no_done", done_cnt_a - d0, 0);
    check("a_reset_stays_idle", 32'(bus_a.busy), 0);

    // Fresh frame after reset.
    r0 = rises_a;
    start_a(12'h5C0, 3'b100, 3'b000);
    wait_done_a("a_done4");
    @(posedge clk); #1;
    check("a_busy_len4", last_run_a, 98);
    check("a_rises4", rises_a - r0, 24);
    check("a_sb_empty4", exp_a.size(), 0);
    check("a_rclk_sclk_overlap", ovl_a, 0);
    check("b_rclk_sclk_overlap", ovl_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
